btn_event_gen: RTL and testbench

Multi-channel push-button front end that turns raw, bouncing button inputs into clean single-cycle events in the system clock domain. Each channel is synchronised, debounced against a 1 ms tick enable, and edge-detected into press and release pulses. It also produces a long-press pulse and optional auto-repeat press pulses. It sits between the board buttons and the game/control logic, which consumes `press` as its "load"/flap strobe.

---
 rtl/btn_event_gen.sv | 133 +++++++++++++
 tb/tb_btn_event_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_gen.sv
// Multi-channel push-button front end: synchronise, debounce on a 1 ms tick enable,
// then emit single-cycle press / release / long-press / auto-repeat events.
module btn_event_gen #(
    parameter int unsigned N       = 4,
    parameter int unsigned DEB_MS  = 20,
    parameter int unsigned HOLD_MS = 500,
    parameter int unsigned REP_MS  = 100
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_tick_1ms,
    input  logic [N-1:0] i_btn_in,
    input  logic [N-1:0] i_rpt_en,
    output logic [N-1:0] o_btn_level,
    output logic [N-1:0] o_press,
    output logic [N-1:0] o_release,
    output logic [N-1:0] o_long_press
);

    localparam int unsigned DW = $clog2(DEB_MS + 1);
    localparam int unsigned HW = $clog2(HOLD_MS + 1);
    localparam int unsigned RW = (REP_MS > 1) ? $clog2(REP_MS) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_MS);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_LONG
    } state_t;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic          r_sync1, r_sync2;
        logic          r_lvl, r_lvl_d;
        logic          r_press, r_release, r_long;
        logic [DW-1:0] r_dcnt;
        logic [HW-1:0] r_hcnt;
        logic [RW-1:0] r_rcnt;
        state_t        r_state, w_state_nxt;
        logic          w_mismatch, w_deb_flip, w_rise, w_fall;
        logic          w_hold_tick, w_long_st, w_rpt_run, w_rep_req;

        assign w_mismatch = r_sync2 ^ r_lvl;
        assign w_deb_flip = i_tick_1ms & w_mismatch & (r_dcnt == DEB_LAST);
        assign w_rise     = w_deb_flip & ~r_lvl;
        assign w_fall     = w_deb_flip & r_lvl;

        assign w_hold_tick = i_tick_1ms & ~w_fall & (r_state == S_HELD) & (r_hcnt == HOLD_LAST);
        assign w_rpt_run   = w_long_st & i_rpt_en[g];
        // A debounced fall on the same tick as a due repeat suppresses the repeat
        assign w_rep_req   = w_rpt_run & i_tick_1ms & ~w_fall & (r_rcnt == REP_LAST);

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_state <= S_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            unique case (r_state)
                S_IDLE:  if (w_rise) w_state_nxt = S_HELD;
                S_HELD: begin
                    if (w_fall)           w_state_nxt = S_IDLE;
                    else if (w_hold_tick) w_state_nxt = S_LONG;
                end
                S_LONG:  if (w_fall) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end

        always_comb begin
            w_long_st = (r_state == S_LONG);
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_lvl     <= 1'b0;
                r_lvl_d   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
                r_dcnt    <= '0;
                r_hcnt    <= '0;
                r_rcnt    <= '0;
            end else begin
                r_sync1 <= i_btn_in[g];
                r_sync2 <= r_sync1;

                if (!w_mismatch) begin
                    r_dcnt <= '0;
                end else if (i_tick_1ms) begin
                    if (w_deb_flip) begin
                        r_lvl  <= r_sync2;
                        r_dcnt <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end

                r_lvl_d   <= r_lvl;
                r_press   <= (r_lvl & ~r_lvl_d) | w_rep_req;
                r_release <= ~r_lvl & r_lvl_d;
                r_long    <= w_hold_tick;

                if (!r_lvl) begin
                    r_hcnt <= '0;
                end else if (i_tick_1ms && !w_fall && r_hcnt != HOLD_MAX) begin
                    r_hcnt <= r_hcnt + 1'b1;
                end

                if (!w_rpt_run || w_fall) begin
                    r_rcnt <= '0;
                end else if (i_tick_1ms) begin
                    r_rcnt <= (r_rcnt == REP_LAST) ? '0 : r_rcnt + 1'b1;
                end
            end
        end

        assign o_btn_level[g]  = r_lvl;
        assign o_press[g]      = r_press;
        assign o_release[g]    = r_release;
        assign o_long_press[g] = r_long;
    end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen (N=2, DEB_MS=4, HOLD_MS=10, REP_MS=3, tick every 5 clk).
module tb_btn_event_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [1:0] btn;
    logic [1:0] rpt;
    logic [1:0] lvl, press, rel, lng;

    int checks = 0;
    int errors = 0;

    int unsigned phase;
    int          tick_no;
    logic        last_tick;
    logic [1:0]  lvl_prev;
    int p_cnt[2], r_cnt[2], l_cnt[2], lvl_chg[2];
    int p_tick[2], r_tick[2], l_tick[2];
    int T, R;

    always #5 clk = ~clk;

    btn_event_gen #(
        .N      (2),
        .DEB_MS (4),
        .HOLD_MS(10),
        .REP_MS (3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tick_1ms  (tick),
        .i_btn_in    (btn),
        .i_rpt_en    (rpt),
        .o_btn_level (lvl),
        .o_press     (press),
        .o_release   (rel),
        .o_long_press(lng)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: tick_no counts ticks consumed at each edge; outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        last_tick = tick;
        if (tick) tick_no++;
        #1;
        for (int c = 0; c < 2; c++) begin
            if (press[c] === 1'b1) begin p_cnt[c]++; p_tick[c] = tick_no; end
            if (rel[c]   === 1'b1) begin r_cnt[c]++; r_tick[c] = tick_no; end
            if (lng[c]   === 1'b1) begin l_cnt[c]++; l_tick[c] = tick_no; end
            if (lvl[c] !== lvl_prev[c]) lvl_chg[c]++;
        end
        lvl_prev = lvl;
        phase = (phase == 4) ? 0 : phase + 1;
        tick  = (phase == 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic to_tick();
        cyc();
        while (!last_tick) cyc();
    endtask

    task automatic to_tick_no(input int k);
        while (tick_no < k) cyc();
    endtask

    task automatic clear();
        for (int c = 0; c < 2; c++) begin
            p_cnt[c] = 0; r_cnt[c] = 0; l_cnt[c] = 0; lvl_chg[c] = 0;
            p_tick[c] = -1; r_tick[c] = -1; l_tick[c] = -1;
        end
    endtask

    initial begin
        rst_n = 1'b0; btn = 2'b11; rpt = 2'b00;
        phase = 1; tick = 1'b0; tick_no = 0; last_tick = 1'b0; lvl_prev = 2'b00;
        clear();

        // Reset with both buttons held
        cycles(3);
        chk("rst_level", 32'(lvl), 32'd0);
        chk("rst_press", 32'(press), 32'd0);
        chk("rst_release", 32'(rel), 32'd0);
        chk("rst_long", 32'(lng), 32'd0);
        to_tick();
        rst_n = 1'b1;
        T = tick_no;
        clear();
        to_tick_no(T + 3);
        chk("rst_level_t3", 32'(lvl), 32'd0);
        to_tick_no(T + 4);
        chk("rst_level_t4", 32'(lvl), 32'd3);
        cycles(20);
        chk("rst_press_cnt0", p_cnt[0], 1);
        chk("rst_press_cnt1", p_cnt[1], 1);
        chk("rst_press_tick0", p_tick[0], T + 4);
        chk("rst_press_tick1", p_tick[1], T + 4);
        to_tick();
        btn = 2'b00;
        T = tick_no;
        to_tick_no(T + 4);
        cycles(3);
        chk("rst_rel_tick0", r_tick[0], T + 4);
        chk("rst_rel_tick1", r_tick[1], T + 4);
        chk("rst_long_none", l_cnt[0] + l_cnt[1], 0);

        // Bounce rejection on ch0
        clear();
        for (int i = 0; i < 8; i++) begin
            cycles(7);
            btn[0] = ~btn[0];
        end
        cycles(4);
        chk("bnc_no_level", lvl_chg[0], 0);
        chk("bnc_no_press", p_cnt[0], 0);
        to_tick();
        btn[0] = 1'b1;
        T = tick_no;
        to_tick_no(T + 4);
        cycles(2);
        chk("bnc_press_cnt", p_cnt[0], 1);
        chk("bnc_press_tick", p_tick[0], T + 4);
        chk("bnc_level_chg", lvl_chg[0], 1);
        to_tick();
        btn[0] = 1'b0;
        to_tick_no(T + 12);

        // Clean press / release on ch1, short of a long press
        clear();
        to_tick();
        btn[1] = 1'b1;
        R = tick_no + 4;
        to_tick_no(R + 2);
        btn[1] = 1'b0;
        to_tick_no(R + 20);
        chk("rel_press_cnt", p_cnt[1], 1);
        chk("rel_press_tick", p_tick[1], R);
        chk("rel_rel_cnt", r_cnt[1], 1);
        chk("rel_rel_tick", r_tick[1], R + 6);
        chk("rel_no_long", l_cnt[1], 0);
        chk("rel_ch0_quiet", p_cnt[0] + r_cnt[0], 0);

        // Long press with auto-repeat on ch0
        clear();
        rpt = 2'b01;
        to_tick();
        btn[0] = 1'b1;
        R = tick_no + 4;
        to_tick_no(R + 12);
        chk("lp_before_rep", p_cnt[0], 1);
        to_tick_no(R + 13);
        cycles(1);
        chk("lp_first_rep_cnt", p_cnt[0], 2);
        chk("lp_first_rep_tick", p_tick[0], R + 13);
        to_tick_no(R + 22);
        btn[0] = 1'b0;
        to_tick_no(R + 30);
        chk("lp_long_cnt", l_cnt[0], 1);
        chk("lp_long_tick", l_tick[0], R + 10);
        chk("lp_press_cnt", p_cnt[0], 6);
        chk("lp_last_rep", p_tick[0], R + 25);
        chk("lp_rel_cnt", r_cnt[0], 1);
        chk("lp_rel_tick", r_tick[0], R + 26);

        // Repeat enable dropped after the first repeat, then re-raised
        clear();
        to_tick();
        btn[0] = 1'b1;
        R = tick_no + 4;
        to_tick_no(R + 13);
        rpt[0] = 1'b0;
        to_tick_no(R + 18);
        rpt[0] = 1'b1;
        to_tick_no(R + 20);
        chk("rd_one_repeat", p_cnt[0], 2);
        to_tick_no(R + 21);
        cycles(1);
        chk("rd_restart_tick", p_tick[0], R + 21);
        to_tick_no(R + 22);
        btn[0] = 1'b0;
        to_tick_no(R + 30);
        chk("rd_press_cnt", p_cnt[0], 4);
        chk("rd_rel_tick", r_tick[0], R + 26);

        // Independent channels, two ticks apart, no repeat
        clear();
        rpt = 2'b00;
        to_tick();
        btn[0] = 1'b1;
        T = tick_no;
        to_tick_no(T + 2);
        btn[1] = 1'b1;
        to_tick_no(T + 8);
        btn[0] = 1'b0;
        to_tick_no(T + 20);
        chk("ind_press0", p_tick[0], T + 4);
        chk("ind_press1", p_tick[1], T + 6);
        chk("ind_rel0", r_tick[0], T + 12);
        chk("ind_long0", l_cnt[0], 0);
        chk("ind_long1_cnt", l_cnt[1], 1);
        chk("ind_long1_tick", l_tick[1], T + 16);
        chk("ind_rel1_none", r_cnt[1], 0);
        chk("ind_press1_cnt", p_cnt[1], 1);
        btn[1] = 1'b0;
        to_tick_no(T + 28);

        // Debounced fall on the same tick as a due repeat
        clear();
        rpt = 2'b01;
        to_tick();
        btn[0] = 1'b1;
        R = tick_no + 4;
        to_tick_no(R + 12);
        btn[0] = 1'b0;
        to_tick_no(R + 22);
        chk("col_press_cnt", p_cnt[0], 2);
        chk("col_press_tick", p_tick[0], R + 13);
        chk("col_rel_cnt", r_cnt[0], 1);
        chk("col_rel_tick", r_tick[0], R + 16);

        // Reset asserted mid-hold: no pulses on exit
        rpt = 2'b00;
        to_tick();
        btn = 2'b11;
        T = tick_no;
        to_tick_no(T + 8);
        rst_n = 1'b0;
        btn = 2'b00;
        cycles(3);
        chk("mid_rst_level", 32'(lvl), 32'd0);
        rst_n = 1'b1;
        clear();
        cycles(30);
        chk("mid_rst_no_press", p_cnt[0] + p_cnt[1], 0);
        chk("mid_rst_no_rel", r_cnt[0] + r_cnt[1], 0);
        chk("mid_rst_no_long", l_cnt[0] + l_cnt[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
